// File: rtl/uart_rx_digit_loader_pkg.sv
// Shared types and constants for the UART digit loader.
// Build with UART_RX_PARITY_CHECK_EN defined for 8E1 framing with a PARITY state.
package uart_digit_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/uart_rx_digit_loader_if.sv
// Serial input and display-side outputs of the digit loader.
// The loader is the master; the display/consumer side is the slave.
interface uart_rx_digit_loader_if;

  logic       rx;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_err;
  logic       parity_err;

  modport master (
    input  rx,
    output digit1, digit2, digit3, digit4,
    output rx_byte, rx_valid, frame_err, cmd_err, parity_err
  );

  modport slave (
    output rx,
    input  digit1, digit2, digit3, digit4,
    input  rx_byte, rx_valid, frame_err, cmd_err, parity_err
  );

endinterface

// File: rtl/uart_rx_digit_loader_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks.
// A synchronous restart holds the phase at zero so sampling aligns to the start edge.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic Clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic          tick_reg;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (restart) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_reg == CW'(DIV - 1)) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/uart_rx_digit_loader.sv
// UART receiver (16x oversampled) that turns ASCII digits into four committed BCD digits.
// Define UART_RX_PARITY_CHECK_EN for 8E1 framing with parity_err reporting.
module uart_rx_digit_loader
  import uart_digit_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 9600
) (
  input  logic                   Clk,
  input  logic                   reset,
  uart_rx_digit_loader_if.master bus
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);

  logic tick;
  logic baud_restart;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .Clk     (Clk),
    .reset   (reset),
    .restart (baud_restart),
    .tick    (tick)
  );

  logic rx_meta_reg;
  logic rx_s_reg;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= bus.rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  rx_state_t  state_reg, state_next;
  logic [3:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_byte_reg, rx_byte_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_CHECK_EN
  logic       parity_bit_reg, parity_bit_next;
  logic       parity_err_reg, parity_err_next;
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      rx_byte_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      rx_byte_reg    <= rx_byte_next;
      rx_valid_reg   <= rx_valid_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_CHECK_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    tick_cnt_next   = tick_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    rx_byte_next    = rx_byte_reg;
    rx_valid_next   = 1'b0;
    frame_err_next  = 1'b0;
    baud_restart    = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        // Holding the divider in restart makes the first START tick phase-locked to the edge.
        baud_restart  = 1'b1;
        tick_cnt_next = '0;
        if (!rx_s_reg) begin
          state_next = START;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt_reg == 4'(MID_SAMPLE - 1)) begin
            tick_cnt_next = '0;
            if (!rx_s_reg) begin
              state_next   = DATA;
              bit_idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_reg == 4'(OVERSAMPLE - 1)) begin
            tick_cnt_next = '0;
            shift_next    = {rx_s_reg, shift_reg[7:1]};
            bit_idx_next  = bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_CHECK_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_CHECK_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt_reg == 4'(OVERSAMPLE - 1)) begin
            tick_cnt_next   = '0;
            parity_bit_next = rx_s_reg;
            state_next      = STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (tick_cnt_reg == 4'(OVERSAMPLE - 1)) begin
            tick_cnt_next = '0;
`ifdef UART_RX_PARITY_CHECK_EN
            // A parity failure outranks a bad stop bit; only the route out depends on the line.
            if (parity_bit_reg != (^shift_reg)) begin
              parity_err_next = 1'b1;
              state_next      = rx_s_reg ? IDLE : WAIT_HIGH;
            end else
`endif
            if (rx_s_reg) begin
              rx_valid_next = 1'b1;
              rx_byte_next  = shift_reg;
              state_next    = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = WAIT_HIGH;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end

      WAIT_HIGH: begin
        if (rx_s_reg) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Digit handling acts on the registered rx_valid pulse, so results land one cycle later.
  logic        byte_is_num;
  logic        byte_is_cr;
  logic [3:0]  new_digit;
  logic [15:0] buf_reg, buf_next;
  logic [15:0] digit_reg, digit_next;
  logic        cmd_err_reg;

  assign byte_is_num = is_digit(rx_byte_reg);
  assign byte_is_cr  = (rx_byte_reg == ASCII_CR);
  assign new_digit   = rx_byte_reg[3:0] - ASCII_ZERO[3:0];

  // Nibble gi holds digit gi+1 counting from the left; shifting pulls from the right neighbour.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] shift_in;

    if (gi == 3) begin : g_last
      assign shift_in = new_digit;
    end else begin : g_inner
      assign shift_in = buf_reg[4*(gi+1) +: 4];
    end

    assign buf_next[4*gi +: 4] =
        !rx_valid_reg ? buf_reg[4*gi +: 4] :
        byte_is_num   ? shift_in :
        byte_is_cr    ? 4'd0 :
                        buf_reg[4*gi +: 4];

    assign digit_next[4*gi +: 4] =
        (rx_valid_reg && byte_is_cr) ? buf_reg[4*gi +: 4] : digit_reg[4*gi +: 4];
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      buf_reg     <= '0;
      digit_reg   <= '0;
      cmd_err_reg <= 1'b0;
    end else begin
      buf_reg     <= buf_next;
      digit_reg   <= digit_next;
      cmd_err_reg <= rx_valid_reg && !byte_is_num && !byte_is_cr;
    end
  end

  assign bus.digit1    = digit_reg[3:0];
  assign bus.digit2    = digit_reg[7:4];
  assign bus.digit3    = digit_reg[11:8];
  assign bus.digit4    = digit_reg[15:12];
  assign bus.rx_byte   = rx_byte_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.cmd_err   = cmd_err_reg;
`ifdef UART_RX_PARITY_CHECK_EN
  assign bus.parity_err = parity_err_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_digit_loader.sv
// Randomised bench for uart_rx_digit_loader against a queue-based display model.
// Honours UART_RX_PARITY_CHECK_EN when the design is built with it.
module tb_uart_rx_digit_loader;
  import uart_digit_pkg::*;

  localparam int CLK_HZ    = 3_200_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BIT_CLKS  = (CLK_HZ / (BAUD_RATE * 16)) * 16;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic reset = 1'b0;

  uart_rx_digit_loader_if bus ();

  uart_rx_digit_loader #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_RATE)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters and timing-rule violations observed on the outputs.
  int valid_cnt = 0, frame_cnt = 0, cmd_cnt = 0, par_cnt = 0;
  int bad_change_cnt = 0, bad_cmd_cnt = 0, bad_excl_cnt = 0;
  logic        prev_valid  = 1'b0;
  logic [7:0]  prev_byte   = 8'h00;
  logic [15:0] prev_digits = 16'h0000;

  always @(negedge Clk) begin
    logic [15:0] cur;
    cur = {bus.digit1, bus.digit2, bus.digit3, bus.digit4};
    if (!reset) begin
      prev_valid  = 1'b0;
      prev_digits = cur;
    end else begin
      if (bus.rx_valid)   valid_cnt++;
      if (bus.frame_err)  frame_cnt++;
      if (bus.cmd_err)    cmd_cnt++;
      if (bus.parity_err) par_cnt++;
      if ((32'(bus.rx_valid) + 32'(bus.frame_err) + 32'(bus.parity_err)) > 1) bad_excl_cnt++;
      if (cur != prev_digits && !(prev_valid && prev_byte == 8'h0D)) bad_change_cnt++;
      if (bus.cmd_err && !(prev_valid && prev_byte != 8'h0D &&
                           !(prev_byte >= 8'h30 && prev_byte <= 8'h39))) bad_cmd_cnt++;
      prev_valid  = bus.rx_valid;
      prev_byte   = bus.rx_byte;
      prev_digits = cur;
    end
  end

  // Reference model: pending digits kept newest-last, at most four.
  int         pend[$];
  logic [3:0] disp[4];
  logic [7:0] model_byte = 8'h00;
  int         frame_no   = 0;

  function automatic logic [15:0] model_digits();
    return {disp[0], disp[1], disp[2], disp[3]};
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int k = 0; k < 4; k++) disp[k] = 4'd0;
    model_byte = 8'h00;
  endtask

  function automatic bit model_accept(input logic [7:0] b);
    int n;
    if (b >= 8'h30 && b <= 8'h39) begin
      pend.push_back(int'(b) - 48);
      if (pend.size() > 4) void'(pend.pop_front());
      return 1'b0;
    end else if (b == 8'h0D) begin
      for (int k = 0; k < 4; k++) disp[k] = 4'd0;
      n = pend.size();
      for (int i = 0; i < n; i++) disp[4 - n + i] = 4'(pend[i]);
      pend.delete();
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input int hold_bits);
    @(negedge Clk);
    bus.rx = 1'b0;
    repeat (BIT_CLKS) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (BIT_CLKS) @(negedge Clk);
    end
    if (PARITY_EN) begin
      bus.rx = (^b) ^ par_flip;
      repeat (BIT_CLKS) @(negedge Clk);
    end
    bus.rx = stop_bit;
    repeat (BIT_CLKS) @(negedge Clk);
    repeat (hold_bits * BIT_CLKS) @(negedge Clk);
    bus.rx = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input logic stop_ok, input logic par_flip,
                          input int hold_bits, input int gap);
    int v0, f0, c0, p0;
    int ev, ef, ec, ep;
    v0 = valid_cnt; f0 = frame_cnt; c0 = cmd_cnt; p0 = par_cnt;
    ev = 0; ef = 0; ec = 0; ep = 0;
    if (PARITY_EN && par_flip) begin
      ep = 1;
    end else if (!stop_ok) begin
      ef = 1;
    end else begin
      ev = 1;
      model_byte = b;
      ec = int'(model_accept(b));
    end
    send_frame(b, stop_ok, par_flip, hold_bits);
    repeat (4) @(negedge Clk);
    #1;
    check_value("rx_valid_count",   32'(valid_cnt - v0), 32'(ev));
    check_value("frame_err_count",  32'(frame_cnt - f0), 32'(ef));
    check_value("cmd_err_count",    32'(cmd_cnt - c0),   32'(ec));
    check_value("parity_err_count", 32'(par_cnt - p0),   32'(ep));
    check_value("rx_byte", 32'(bus.rx_byte), 32'(model_byte));
    check_value("digits", 32'({bus.digit1, bus.digit2, bus.digit3, bus.digit4}),
                32'(model_digits()));
    $display("frame %0d byte %02h stop %0b pflip %0b valid %0d ferr %0d cmd %0d perr %0d digits %0d%0d%0d%0d",
             frame_no, b, stop_ok, par_flip, valid_cnt - v0, frame_cnt - f0, cmd_cnt - c0,
             par_cnt - p0, bus.digit1, bus.digit2, bus.digit3, bus.digit4);
    frame_no++;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic send_string(input logic [7:0] s[$]);
    foreach (s[i]) do_frame(s[i], 1'b1, 1'b0, 0, int'($urandom_range(0, 6)));
  endtask

  initial begin
    logic [7:0] seq[$];
    logic [7:0] b;
    int v0, f0, c0, p0, r;

    bus.rx = 1'b1;
    model_clear();
    repeat (5) @(negedge Clk);
    #1;
    check_value("reset_digits", 32'({bus.digit1, bus.digit2, bus.digit3, bus.digit4}), 32'h0);
    check_value("reset_rx_byte", 32'(bus.rx_byte), 32'h0);
    check_value("reset_pulses", 32'({bus.rx_valid, bus.frame_err, bus.cmd_err, bus.parity_err}), 32'h0);
    @(negedge Clk);
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge Clk);

    seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
    send_string(seq);
    seq = '{8'h37, 8'h38, 8'h0D};
    send_string(seq);
    seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h0D};
    send_string(seq);
    do_frame(8'h41, 1'b1, 1'b0, 0, 3);
    do_frame(8'h0D, 1'b1, 1'b0, 0, 3);

    // Break: bad stop bit, line held low for three more bit times.
    do_frame(8'h35, 1'b0, 1'b0, 3, 8);
    seq = '{8'h39, 8'h0D};
    send_string(seq);

    // Short low glitch on an idle line must be rejected silently.
    v0 = valid_cnt; f0 = frame_cnt; c0 = cmd_cnt; p0 = par_cnt;
    bus.rx = 1'b0;
    repeat (10) @(negedge Clk);
    bus.rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge Clk);
    #1;
    check_value("glitch_pulses", 32'((valid_cnt - v0) + (frame_cnt - f0) + (cmd_cnt - c0) + (par_cnt - p0)), 32'h0);
    check_value("glitch_digits", 32'({bus.digit1, bus.digit2, bus.digit3, bus.digit4}), 32'(model_digits()));

    // Reset in the middle of data bit 4 of a '7' frame.
    v0 = valid_cnt; f0 = frame_cnt;
    b = 8'h37;
    @(negedge Clk);
    bus.rx = 1'b0;
    repeat (BIT_CLKS) @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      repeat (BIT_CLKS) @(negedge Clk);
    end
    bus.rx = b[4];
    repeat (BIT_CLKS / 2) @(negedge Clk);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_value("async_reset_digits", 32'({bus.digit1, bus.digit2, bus.digit3, bus.digit4}), 32'h0);
    check_value("async_reset_rx_byte", 32'(bus.rx_byte), 32'h0);
    check_value("async_reset_pulses", 32'({bus.rx_valid, bus.frame_err, bus.cmd_err, bus.parity_err}), 32'h0);
    bus.rx = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge Clk);
    check_value("aborted_frame_pulses", 32'((valid_cnt - v0) + (frame_cnt - f0)), 32'h0);
    seq = '{8'h35, 8'h0D};
    send_string(seq);

    if (PARITY_EN) begin
      do_frame(8'h33, 1'b1, 1'b0, 0, 2);
      do_frame(8'h33, 1'b1, 1'b1, 0, 2);
      do_frame(8'h34, 1'b0, 1'b1, 1, 4);
      do_frame(8'h0D, 1'b1, 1'b0, 0, 2);
    end

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      b = ASCII_ZERO + 8'($urandom_range(0, 9));
      else if (r < 70) b = ASCII_CR;
      else             b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0)
        do_frame(b, 1'b0, 1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 20)));
      else
        do_frame(b, 1'b1, PARITY_EN && ($urandom_range(0, 9) == 0), 0, int'($urandom_range(0, 20)));
    end

    check_value("digit_change_timing", 32'(bad_change_cnt), 32'h0);
    check_value("cmd_err_timing", 32'(bad_cmd_cnt), 32'h0);
    check_value("pulse_exclusivity", 32'(bad_excl_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_digit_loader.md
Name: uart_rx_digit_loader

Overview:
UART 8N1 receiver with 16x oversampling. Decodes ASCII digit commands into four BCD display digits. Sits directly upstream of the 4-digit 7-segment display top and drives its digit1..digit4 inputs from the serial line. Digits are shifted into a staging buffer and committed to the outputs only on carriage return, so the display never shows partial entries.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
BAUD, 9600, serial bit rate.
OVERSAMPLE, 16, ticks per bit. Fixed value, used from the package constant.

Ports:
Clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
rx  input  1  serial line, idles high. Asynchronous to Clk.
digit1  output  4  leftmost BCD digit.
digit2  output  4  BCD digit.
digit3  output  4  BCD digit.
digit4  output  4  rightmost BCD digit.
rx_byte  output  8  last accepted byte.
rx_valid  output  1  1-cycle pulse; rx_byte updated.
frame_err  output  1  1-cycle pulse; stop bit sampled low.
cmd_err  output  1  1-cycle pulse; byte is neither '0'..'9' nor CR.
parity_err  output  1  1-cycle pulse on parity mismatch. Constant 0 without the macro.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; rx_byte = 8'h00.
  - FSM = IDLE; staging buffer = 0; synchronizer flops = 1.
- rx input: passes through a 2-flop synchronizer, giving rx_s.
- Tick generator:
  - DIV = CLK_FREQ_HZ/(BAUD*16), integer floor, minimum 1.
  - tick is a 1-cycle pulse every DIV clocks.
  - Counter restarts at 0 when the FSM leaves IDLE, which aligns sampling to the start edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 → START; tick count cleared.
  - START: after 8 ticks, sample rx_s.
    - 0 → DATA, bit index = 0.
    - 1 → IDLE (glitch rejected; no pulse).
  - DATA: sample every 16 ticks at mid-bit, LSB first. After bit 7 → STOP.
  - STOP: sample at 16 ticks.
    - 1 → assert rx_valid, load rx_byte, go to IDLE.
    - 0 → assert frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers a held-low line (break); no further pulses are produced while waiting.
- Digit logic (acts in the cycle rx_valid is high; results visible the next cycle):
  - Byte 0x30..0x39: shift the buffer left, b1<=b2, b2<=b3, b3<=b4, b4<=byte-0x30 (4-bit subtraction).
    - More than 4 digits before CR: the oldest digits drop off the left.
  - Byte 0x0D: digitN <= bN for all four; buffer cleared to 0 in the same cycle. A CR with an empty buffer commits 0000.
  - Any other byte: cmd_err pulse one cycle after rx_valid; buffer and outputs unchanged.
- Latency: digit outputs change 1 cycle after the rx_valid pulse of the CR byte. Between commits they hold their value.
- Reset asserted mid-frame: the frame is abandoned, no pulses are issued, and the buffer is cleared.
- Pulse exclusivity: rx_valid, frame_err and parity_err are mutually exclusive per frame.

Optional Feature:
- Macro: UART_RX_PARITY_CHECK_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP, sampled at mid-bit.
  - Even-parity mismatch: parity_err pulse at the stop-bit sample point. Byte discarded (no rx_valid, no digit action). FSM → IDLE if stop bit is high, otherwise → WAIT_HIGH.
  - Parity and stop both bad: parity_err only.
- Not defined: 8N1 framing; parity_err tied to 0.

Decomposition:
- Package uart_digit_pkg contains:
  - state enum typedef;
  - OVERSAMPLE=16, MID_SAMPLE=8;
  - ASCII_ZERO=8'h30, ASCII_NINE=8'h39, ASCII_CR=8'h0D.
- One sub-module, uart_baud_tick: parameterised divider with outputs tick and a synchronous restart input.
- The FSM, shift register and digit buffer stay in the top module.

Test Plan (CLK_FREQ_HZ=50e6, BAUD=9600, DIV=325, bit time = 5200 clocks):
- Send '1','2','3','4',0x0D → five rx_valid pulses; digit1..4 = 1,2,3,4 one cycle after the fifth pulse; no digit change before it.
- After the previous test, send '7','8',CR → digits 0,0,7,8. Send '1'..'6',CR → digits 3,4,5,6.
- Send 0x41 → cmd_err pulse, rx_byte=0x41, digits unchanged. Send CR alone → digits 0,0,0,0.
- Send 0x35 with stop bit forced low, then hold rx low 3 bit times → a single frame_err, no rx_valid, FSM stays in WAIT_HIGH. After rx returns high, '9',CR → digit4=9.
- Idle-line low glitch of 2000 clocks → no pulse of any kind. Assert reset during DATA bit 4 → all outputs 0 asynchronously; the next clean frame is received correctly.
- With UART_RX_PARITY_CHECK_EN: 0x33 with even parity bit 0 → rx_valid. Same byte with parity bit 1 → parity_err only, buffer unchanged.
